// File: rtl/nq_fetch_pkg.sv
// nq_fetch_pkg: shared types and constants for the instruction-pair fetcher.
// Holds the APB read FSM state encoding, datapath widths and the fetch stride.
package nq_fetch_pkg;

   // Byte address width of the fetch pointer and APB address bus.
   localparam int ADDR_W = 16;
   // Width of one instruction; a fetched word carries two of them.
   localparam int INST_W = 16;
   // Width of the APB read data word (one instruction pair).
   localparam int DATA_W = 2 * INST_W;

   // One APB word holds one instruction pair, so the pointer moves 4 bytes.
   localparam logic [ADDR_W-1:0] FETCH_STRIDE = 16'd4;

   // APB master phases: IDLE (bus quiet), SETUP (psel), ACCESS (psel+penable).
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   // Force a byte address onto a 4-byte word boundary.
   function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/apb_read_fsm.sv
// apb_read_fsm: three-phase APB read master sequencer (IDLE/SETUP/ACCESS).
// Owns only the bus phase; the caller decides when to start and whether a
// completing transfer may chain straight into the next SETUP.
//
// Handshake: a transfer begins with psel=1, penable=0 (SETUP) for exactly one
// cycle, then psel=1, penable=1 (ACCESS) until pready=1. The transfer completes
// on the rising edge where psel & penable & pready are all 1; xfer_done marks
// that cycle. The address must be held by the caller for the whole transfer.
module apb_read_fsm
   import nq_fetch_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start_req,
   input  logic       cont_req,
   input  logic       pready,
   output logic       psel,
   output logic       penable,
   output logic       xfer_done,
   output apb_state_e state_dbg
);

   apb_state_e state;
   apb_state_e state_nxt;

   // State register; reset always lands in IDLE, even mid-transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and bus-control decode for the current phase.
   always_comb begin
      state_nxt = state;
      psel      = 1'b0;
      penable   = 1'b0;
      xfer_done = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_req) begin
               state_nxt = ST_SETUP;
            end
         end
         ST_SETUP: begin
            psel      = 1'b1;
            state_nxt = ST_ACCESS;
         end
         ST_ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            if (pready) begin
               xfer_done = 1'b1;
               // Chaining straight into SETUP gives one pair every 2 cycles.
               state_nxt = cont_req ? ST_SETUP : ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign state_dbg = state;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches 32-bit instruction pairs over APB and hands them to
// the prefetch buffer with a one-cycle write pulse.
// The bus phase lives in apb_read_fsm; this file owns the fetch pointer,
// pair capture, stall-pending delivery and branch redirect/discard.
// Optional feature: define FETCH_ERR_EN to add the pslverr input and a sticky
// fetch_err output; an errored completion halts fetching until rst.
module fetch_sequencer
   import nq_fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_flg,
   input  logic              branch_en,
   input  logic [ADDR_W-1:0] branch_addr,
   output logic [ADDR_W-1:0] paddr,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   output logic [INST_W-1:0] inst1,
   output logic [INST_W-1:0] inst2,
   output logic              write,
`ifdef FETCH_ERR_EN
   input  logic              pslverr,
   output logic              fetch_err,
`endif
   output logic              fetch_busy
);

   // Fetch pointer: byte address of the next pair to request.
   logic [ADDR_W-1:0] fptr;
   // A captured pair is waiting for stall_flg to drop.
   logic              pending;
   // The transfer now on the bus was overtaken by a branch; drop its data.
   logic              discard_q;

   logic              xfer_done;
   logic              err_hit;
   logic              halted;
   logic              take_data;
   logic              start_req;
   logic              cont_req;
   apb_state_e        fsm_state;

`ifdef FETCH_ERR_EN
   logic              fetch_err_q;

   assign err_hit   = xfer_done & pslverr;
   assign halted    = fetch_err_q;
   assign fetch_err = fetch_err_q;

   // Sticky slave-error flag; only rst clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_err_q <= 1'b0;
      end else if (err_hit) begin
         fetch_err_q <= 1'b1;
      end
   end
`else
   assign err_hit = 1'b0;
   assign halted  = 1'b0;
`endif

   // A completion is kept only if no branch hit it during or at completion.
   assign take_data = xfer_done & ~branch_en & ~discard_q & ~err_hit;

   // A new transfer may start only once any held pair has been delivered.
   assign start_req = ~stall_flg & ~pending & ~halted;

   // Chain the next SETUP only when nothing is asking the fetcher to pause.
   assign cont_req  = ~stall_flg & ~branch_en & ~err_hit;

   apb_read_fsm u_apb_read_fsm (
      .clk       (clk),
      .rst       (rst),
      .start_req (start_req),
      .cont_req  (cont_req),
      .pready    (pready),
      .psel      (psel),
      .penable   (penable),
      .xfer_done (xfer_done),
      .state_dbg (fsm_state)
   );

   // The bus address tracks the fetch pointer; this master never writes.
   assign paddr      = fptr;
   assign pwrite     = 1'b0;
   assign fetch_busy = psel | pending;

   // Fetch pointer: redirect on branch, otherwise step past each kept pair.
   always_ff @(posedge clk) begin
      if (rst) begin
         fptr <= align_word(RESET_PC);
      end else if (branch_en) begin
         fptr <= align_word(branch_addr);
      end else if (take_data) begin
         // Natural 16-bit overflow takes 0xFFFC back to 0x0000.
         fptr <= fptr + FETCH_STRIDE;
      end
   end

   // Instruction pair register; holds its value until the next kept pair.
   always_ff @(posedge clk) begin
      if (rst) begin
         inst1 <= '0;
         inst2 <= '0;
      end else if (take_data) begin
         inst1 <= prdata[INST_W-1:0];
         inst2 <= prdata[DATA_W-1:INST_W];
      end
   end

   // Pending flag: a pair captured under stall waits here; a branch drops it.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= 1'b0;
      end else if (branch_en) begin
         pending <= 1'b0;
      end else if (take_data) begin
         pending <= stall_flg;
      end else if (pending && !stall_flg) begin
         pending <= 1'b0;
      end
   end

   // Write pulse: one cycle after a pair is captured or released from pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         write <= 1'b0;
      end else begin
         write <= ~branch_en & ~stall_flg & (take_data | pending);
      end
   end

   // Discard marker: set by a branch while a transfer is on the bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         discard_q <= 1'b0;
      end else if (xfer_done) begin
         discard_q <= 1'b0;
      end else if (branch_en && (fsm_state != ST_IDLE)) begin
         discard_q <= 1'b1;
      end
   end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, giving the byte address of the first instruction pair fetched after reset; bits [1:0] are ignored.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  system reset, synchronous, active-high.
REQ-004 stall_flg  input  1  pipeline stall; while high, no new fetch is started and no pair is delivered.
REQ-005 branch_en  input  1  one-cycle redirect request.
REQ-006 branch_addr  input  16  redirect byte address; bits [1:0] are treated as 0.
REQ-007 paddr  output  16  APB read address, 4-byte aligned.
REQ-008 psel, penable, pwrite  output  1 each  APB master controls; pwrite is constant 0.
REQ-009 prdata  input  32  APB read data; [15:0] is the first instruction, [31:16] the second.
REQ-010 pready  input  1  APB transfer completion.
REQ-011 inst1, inst2  output  16 each  instruction pair to the prefetch buffer.
REQ-012 write  output  1  one-cycle pulse marking inst1/inst2 valid.
REQ-013 fetch_busy  output  1  high while psel is high or a captured pair is pending delivery.

Function
REQ-014 The FSM SHALL have states IDLE (psel=0,penable=0), SETUP (psel=1,penable=0) and ACCESS (psel=1,penable=1), and paddr SHALL equal the internal fetch pointer (fptr) in SETUP and ACCESS.
REQ-015 IDLE->SETUP when stall_flg=0 and no pair is pending; SETUP->ACCESS unconditionally; ACCESS stays while pready=0.
REQ-016 ACCESS with pready=1 SHALL go to SETUP if stall_flg=0 and branch_en=0 in that cycle, otherwise to IDLE, so that back-to-back transfers run at one pair per 2 cycles.
REQ-017 On a non-discarded completion, prdata SHALL be registered into inst1/inst2 and fptr SHALL advance by 4, wrapping 16'hFFFC->16'h0000.
REQ-018 If stall_flg=0 at the completing edge, write SHALL be 1 for exactly the following cycle; otherwise the pair SHALL be held pending and write SHALL pulse in the cycle after the first edge at which stall_flg=0.
REQ-019 write SHALL never be high for two consecutive cycles, and inst1/inst2 SHALL remain stable while a pair is pending or after delivery until the next capture.
REQ-020 On branch_en=1, fptr SHALL be loaded with {branch_addr[15:2],2'b00} at that edge, and any pending pair SHALL be dropped without a write pulse.
REQ-021 A transfer in SETUP or ACCESS at a branch SHALL run to APB completion, and its data, including data completing in the same cycle as branch_en, SHALL be discarded (no capture, no write, fptr not advanced).
REQ-022 If branch_en and stall_flg are high together, fptr SHALL still load and fetching SHALL resume from the new address once stall_flg falls.

Reset
REQ-023 When rst=1 at an edge, the block SHALL enter IDLE with fptr=RESET_PC aligned, psel=penable=pwrite=write=0, inst1=inst2=16'h0000, no pending pair, and fetch_busy=0; this SHALL hold even mid-transfer.
REQ-024 The first SETUP SHALL occur in the second cycle after rst deasserts, provided stall_flg=0.

Configuration
REQ-025 When FETCH_ERR_EN is defined, the block SHALL add input pslverr (1) and output fetch_err (1, reset 0); a completion with pslverr=1 SHALL set sticky fetch_err, be discarded per REQ-021, and return the FSM to IDLE with fetching halted until rst.
REQ-026 When FETCH_ERR_EN is undefined, neither port SHALL exist and every completion SHALL be treated as error-free.

Structure
REQ-027 Package nq_fetch_pkg SHALL hold the FSM state enum, the fetch stride constant (4) and the instruction/address width constants.
REQ-028 The APB state machine SHALL be a sub-module named apb_read_fsm, with pair capture, pending logic and fptr control kept in fetch_sequencer.

Verification
REQ-029 Reset with RESET_PC=16'h0100 and pready=1: paddr=0x0100, 0x0104 and 0x0108 in successive SETUPs 2 cycles apart, with write pulsing every 2 cycles and inst1/inst2 matching prdata halves.
REQ-030 pready held low 3 cycles in ACCESS: psel/penable held, paddr stable, and exactly one write pulse after completion.
REQ-031 stall_flg high across a completion for 4 cycles: no write during the stall, write pulses once in the cycle after stall_flg falls, and the next SETUP follows.
REQ-032 branch_en with branch_addr=0x2002 during ACCESS completing with prdata=0xDEADBEEF: no write for that data, and the next SETUP has paddr=0x2000.
REQ-033 fptr=0xFFFC: the completion is delivered and the next paddr=0x0000.
REQ-034 With FETCH_ERR_EN, pslverr=1 at completion: fetch_err=1, no write, psel stays 0 until rst.
